// File: rtl/uart_fmt_pkg.sv
// -----------------------------------------------------------------------------
// uart_fmt_pkg
//   Shared definitions for the value formatter:
//   - fmt_state_e : one-hot FSM encoding (7 states)
//   - ASCII constants used while packing the output string
//   - calc_ndig() : decimal digits needed for an unsigned DATA_W-bit value
// -----------------------------------------------------------------------------
package uart_fmt_pkg;

  typedef enum logic [6:0] {
    ST_IDLE  = 7'b000_0001,
    ST_LATCH = 7'b000_0010,
    ST_CONV  = 7'b000_0100,
    ST_PACK  = 7'b000_1000,
    ST_REQ   = 7'b001_0000,
    ST_WAIT  = 7'b010_0000,
    ST_DONE  = 7'b100_0000
  } fmt_state_e;

  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // ceil(data_w * log10(2)) using a fixed-point log10(2) = 0.30103.
  function automatic int calc_ndig(input int data_w);
    return (data_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential double-dabble binary-to-BCD converter. A start pulse loads
//   bin; the conversion then takes exactly DATA_W cycles (one shift each).
//   Ports:
//     sys_clk, sys_rst : clock, synchronous active-high reset
//     start            : load bin and begin conversion
//     bin              : unsigned binary input, sampled with start
//     busy             : conversion in progress
//     done             : high in the final conversion cycle, so a consumer
//                        advancing on done sees a valid bcd the cycle after
//     bcd              : NDIG packed BCD digits, digit 0 in bcd[3:0]
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import uart_fmt_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NDIG   = calc_ndig(DATA_W)
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   bin,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] bin_q;
  logic [4*NDIG-1:0] bcd_q;
  logic [4*NDIG-1:0] adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;

  // "Add 3 to every nibble >= 5" before each shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      bin_q  <= bin;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bcd_q <= {adj[4*NDIG-2:0], bin_q[DATA_W-1]};
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) busy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == LAST);
  assign bcd  = bcd_q;

endmodule

// File: rtl/uart_value_formatter.sv
// -----------------------------------------------------------------------------
// uart_value_formatter
//   Formats "TAG=<decimal>" from a binary value and an ASCII tag, hands the
//   string to the downstream UART string transmitter with one tx_req, waits
//   for tx_done (optionally with a timeout) and pulses fmt_done.
//   Ports:
//     sys_clk, sys_rst     : clock, synchronous active-high reset
//     val, val_signed      : value and its signedness (two's complement if 1)
//     tag                  : ASCII tag, byte 0 = tag[7:0] sent first, 0 bytes skipped
//     fmt_req              : start request, accepted only in IDLE
//     fmt_busy             : high in every state except IDLE
//     fmt_done, fmt_err    : completion pulse, err = tx_done timeout
//     tx_string, tx_length : packed string (char k at [8k+7:8k]) and length
//     tx_req               : one-cycle request to the string transmitter
//     tx_busy, tx_done     : transmitter busy level and finished pulse
// -----------------------------------------------------------------------------
module uart_value_formatter
  import uart_fmt_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int TAG_BYTES  = 4,
  parameter int TX_TIMEOUT = 0
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [DATA_W-1:0]      val,
  input  logic                   val_signed,
  input  logic [8*TAG_BYTES-1:0] tag,
  input  logic                   fmt_req,
  output logic                   fmt_busy,
  output logic                   fmt_done,
  output logic                   fmt_err,
  output logic [1023:0]          tx_string,
  output logic [7:0]             tx_length,
  output logic                   tx_req,
  input  logic                   tx_busy,
  input  logic                   tx_done
);

  localparam int NDIG   = calc_ndig(DATA_W);
  localparam int N_SLOT = TAG_BYTES + 2 + NDIG;
  localparam int SLOT_W = $clog2(N_SLOT + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOT - 1);

  fmt_state_e state_q, state_d;

  logic [8*TAG_BYTES-1:0] tag_q;
  logic                   sign_q;
  logic [SLOT_W-1:0]      slot_q;
  logic [6:0]             wr_idx_q;
  logic [6:0]             wr_next;
  logic                   seen_nz_q;
  logic [1023:0]          tx_string_q;
  logic [7:0]             tx_length_q;
  logic [31:0]            wait_cnt_q;
  logic                   err_q;

  // Magnitude in DATA_W unsigned bits: -2^(DATA_W-1) maps to 2^(DATA_W-1).
  logic              sign_now;
  logic [DATA_W-1:0] mag;
  assign sign_now = val_signed & val[DATA_W-1];
  assign mag      = sign_now ? -val : val;

  logic              conv_busy;
  logic              conv_done;
  logic [4*NDIG-1:0] bcd;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .NDIG   (NDIG)
  ) u_bin2bcd (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (state_q == ST_LATCH),
    .bin     (mag),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (bcd)
  );

  // fmt_done lands TX_TIMEOUT cycles after the tx_req cycle: the request
  // cycle plus TX_TIMEOUT-1 WAIT cycles, counted from 0 on WAIT entry.
  logic timed_out;
  assign timed_out = (TX_TIMEOUT != 0) && ((wait_cnt_q + 32'd2) >= 32'(TX_TIMEOUT));

  // Next-state logic.
  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (fmt_req)   state_d = ST_LATCH;
      ST_LATCH:                state_d = ST_CONV;
      ST_CONV:  if (conv_done) state_d = ST_PACK;
      ST_PACK:  if (slot_q == LAST_SLOT) state_d = ST_REQ;
      ST_REQ:   if (!tx_busy)  state_d = ST_WAIT;
      ST_WAIT:  if (tx_done || timed_out) state_d = ST_DONE;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Character selected by the current PACK slot.
  logic [7:0] ch;
  logic       emit;
  logic       is_digit;
  logic [3:0] nib;
  int         slot_i;
  int         dig_i;

  always_comb begin
    ch       = 8'h00;
    emit     = 1'b0;
    is_digit = 1'b0;
    nib      = 4'h0;
    slot_i   = int'(slot_q);
    dig_i    = 0;
    if (slot_i < TAG_BYTES) begin
      ch   = tag_q[8*slot_i +: 8];
      emit = (ch != 8'h00);
    end else if (slot_i == TAG_BYTES) begin
      ch   = ASCII_EQ;
      emit = 1'b1;
    end else if (slot_i == TAG_BYTES + 1) begin
      ch   = ASCII_MINUS;
      emit = sign_q;
    end else begin
      // Most significant digit first; the final digit always goes out so a
      // zero value still prints "0".
      dig_i    = slot_i - TAG_BYTES - 2;
      nib      = bcd[4*(NDIG-1-dig_i) +: 4];
      ch       = ASCII_ZERO + {4'h0, nib};
      is_digit = 1'b1;
      emit     = (nib != 4'h0) || seen_nz_q || (dig_i == NDIG - 1);
    end
  end

  assign wr_next = wr_idx_q + {6'd0, emit};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the 1024-bit string register is reset as well because its
  // value is visible on tx_string and must read 0 out of reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tag_q       <= '0;
      sign_q      <= 1'b0;
      slot_q      <= '0;
      wr_idx_q    <= '0;
      seen_nz_q   <= 1'b0;
      tx_string_q <= '0;
      tx_length_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_LATCH: begin
          tag_q       <= tag;
          sign_q      <= sign_now;
          slot_q      <= '0;
          wr_idx_q    <= '0;
          seen_nz_q   <= 1'b0;
          tx_string_q <= '0;
          tx_length_q <= '0;
          err_q       <= 1'b0;
        end
        ST_PACK: begin
          slot_q <= slot_q + 1'b1;
          if (emit) begin
            tx_string_q[8*int'(wr_idx_q) +: 8] <= ch;
            wr_idx_q <= wr_next;
          end
          if (emit && is_digit) seen_nz_q <= 1'b1;
          if (slot_q == LAST_SLOT) tx_length_q <= {1'b0, wr_next};
        end
        ST_REQ: begin
          if (!tx_busy) wait_cnt_q <= '0;
        end
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 32'd1;
          if (state_d == ST_DONE) err_q <= ~tx_done;
        end
        default: ;
      endcase
    end
  end

  assign fmt_busy  = (state_q != ST_IDLE);
  assign fmt_done  = (state_q == ST_DONE);
  assign fmt_err   = (state_q == ST_DONE) & err_q;
  assign tx_req    = (state_q == ST_REQ) & ~tx_busy;
  assign tx_string = tx_string_q;
  assign tx_length = tx_length_q;

endmodule

// File: tb/tb_uart_value_formatter.sv
// -----------------------------------------------------------------------------
// tb_uart_value_formatter
//   Directed bench for uart_value_formatter (DATA_W=32, TAG_BYTES=4,
//   TX_TIMEOUT=50). The bench plays the string transmitter: it drives
//   tx_busy/tx_done and counts tx_req / fmt_done pulses per job.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_value_formatter;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [31:0]   val;
  logic          val_signed;
  logic [31:0]   tag;
  logic          fmt_req;
  logic          fmt_busy;
  logic          fmt_done;
  logic          fmt_err;
  logic [1023:0] tx_string;
  logic [7:0]    tx_length;
  logic          tx_req;
  logic          tx_busy;
  logic          tx_done;

  int checks   = 0;
  int failures = 0;

  localparam int REQ_LAT = 49;  // 1 + DATA_W + N_SLOT at these parameters
  localparam int TMO     = 50;

  uart_value_formatter #(
    .DATA_W     (32),
    .TAG_BYTES  (4),
    .TX_TIMEOUT (TMO)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .val        (val),
    .val_signed (val_signed),
    .tag        (tag),
    .fmt_req    (fmt_req),
    .fmt_busy   (fmt_busy),
    .fmt_done   (fmt_done),
    .fmt_err    (fmt_err),
    .tx_string  (tx_string),
    .tx_length  (tx_length),
    .tx_req     (tx_req),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 sys_clk = ~sys_clk;

  // Char k of s at bits [8k+7:8k].
  function automatic logic [1023:0] mk_str(input string s);
    logic [1023:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  // Tag byte 0 = first character of s; unused bytes are 0.
  function automatic logic [31:0] mk_tag(input string s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < s.len() && i < 4; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // One complete job. n counts cycles after the edge that samples fmt_req.
  task automatic run_job(input string name, input string tag_s, input logic [31:0] v,
                         input logic sgn, input string exp_s, input int busy_until,
                         input bit give_done, input bit poke_req);
    int n, req_n, req_cnt, done_n, done_cnt, exp_req, exp_done;
    logic err_seen, busy_seen;
    logic [1023:0] exp_str, str_at_req;
    logic [7:0] exp_len, len_at_req;
    exp_str  = mk_str(exp_s);
    exp_len  = 8'(exp_s.len());
    exp_req  = (busy_until > REQ_LAT) ? busy_until : REQ_LAT;
    exp_done = exp_req + (give_done ? 4 : TMO);
    req_n = -1; done_n = -1; req_cnt = 0; done_cnt = 0;
    err_seen = 1'b0; str_at_req = '0; len_at_req = '0;

    tag = mk_tag(tag_s); val = v; val_signed = sgn;
    tx_busy = (busy_until > 0); tx_done = 1'b0; fmt_req = 1'b1;
    step();
    fmt_req = 1'b0;
    n = 0;
    busy_seen = fmt_busy;
    while (n < 400 && !(done_n >= 0 && n >= done_n + 5)) begin
      step();
      n++;
      fmt_req = poke_req && (n == 20 || n == 60 || n == 120);
      tx_busy = (n < busy_until);
      tx_done = give_done && (req_n >= 0) && (n == req_n + 3);
      #1;
      if (tx_req) begin
        req_cnt++;
        if (req_n < 0) begin
          req_n = n; str_at_req = tx_string; len_at_req = tx_length;
        end
      end
      if (fmt_done) begin
        done_cnt++;
        if (done_n < 0) begin
          done_n = n; err_seen = fmt_err;
        end
      end
    end
    tx_busy = 1'b0; tx_done = 1'b0; fmt_req = 1'b0;

    checks++;
    if (busy_seen !== 1'b1) begin
      failures++; $display("FAIL %s fmt_busy_in_latch got=%b exp=1", name, busy_seen);
    end
    checks++;
    if (req_n !== exp_req) begin
      failures++; $display("FAIL %s tx_req_latency got=%0d exp=%0d", name, req_n, exp_req);
    end
    checks++;
    if (req_cnt !== 1) begin
      failures++; $display("FAIL %s tx_req_count got=%0d exp=1", name, req_cnt);
    end
    checks++;
    if (done_n !== exp_done) begin
      failures++; $display("FAIL %s fmt_done_cycle got=%0d exp=%0d", name, done_n, exp_done);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++; $display("FAIL %s fmt_done_count got=%0d exp=1", name, done_cnt);
    end
    checks++;
    if (err_seen !== !give_done) begin
      failures++; $display("FAIL %s fmt_err got=%b exp=%b", name, err_seen, !give_done);
    end
    checks++;
    if (str_at_req !== exp_str) begin
      failures++;
      $display("FAIL %s tx_string_at_req got=%h exp=%h", name, str_at_req[127:0], exp_str[127:0]);
    end
    checks++;
    if (len_at_req !== exp_len) begin
      failures++; $display("FAIL %s tx_length_at_req got=%0d exp=%0d", name, len_at_req, exp_len);
    end
    checks++;
    if (tx_string !== exp_str || tx_length !== exp_len) begin
      failures++;
      $display("FAIL %s string_stable_after_done got=%h/%0d exp=%h/%0d", name,
               tx_string[127:0], tx_length, exp_str[127:0], exp_len);
    end
    checks++;
    if (fmt_busy !== 1'b0) begin
      failures++; $display("FAIL %s fmt_busy_after got=%b exp=0", name, fmt_busy);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; val = '0; val_signed = 1'b0; tag = '0;
    fmt_req = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
    repeat (3) step();
    sys_rst = 1'b0;
    #1;
    checks++;
    if ({fmt_busy, fmt_done, fmt_err, tx_req} !== 4'b0000) begin
      failures++;
      $display("FAIL reset control_outputs got=%b exp=0000", {fmt_busy, fmt_done, fmt_err, tx_req});
    end
    checks++;
    if (tx_string !== '0 || tx_length !== 8'd0) begin
      failures++;
      $display("FAIL reset string got=%h/%0d exp=0/0", tx_string[127:0], tx_length);
    end
  endtask

  task automatic test_basic();
    run_job("basic", "FREQ", 32'd12345, 1'b0, "FREQ=12345", 0, 1'b1, 1'b0);
  endtask

  task automatic test_unsigned_bounds();
    run_job("zero", "FREQ", 32'd0, 1'b0, "FREQ=0", 0, 1'b1, 1'b0);
    run_job("umax", "FREQ", 32'hFFFF_FFFF, 1'b0, "FREQ=4294967295", 0, 1'b1, 1'b0);
  endtask

  task automatic test_signed();
    run_job("neg1", "FREQ", 32'hFFFF_FFFF, 1'b1, "FREQ=-1", 0, 1'b1, 1'b0);
    run_job("smin", "FREQ", 32'h8000_0000, 1'b1, "FREQ=-2147483648", 0, 1'b1, 1'b0);
    run_job("spos", "AB", 32'd905, 1'b1, "AB=905", 0, 1'b1, 1'b0);
  endtask

  task automatic test_sparse_tag();
    run_job("sparse", "V", 32'd7, 1'b0, "V=7", 0, 1'b1, 1'b0);
    checks++;
    if (tx_string[1023:24] !== '0) begin
      failures++; $display("FAIL sparse upper_bytes got=%h exp=0", tx_string[127:24]);
    end
  endtask

  task automatic test_back_pressure();
    // tx_busy holds REQ for 100 cycles; fmt_req pokes while busy are ignored.
    run_job("backpressure", "TEMP", 32'd300, 1'b0, "TEMP=300", REQ_LAT + 100, 1'b1, 1'b1);
    repeat (20) step();
    checks++;
    if (fmt_busy !== 1'b0 || tx_req !== 1'b0) begin
      failures++;
      $display("FAIL backpressure no_second_job got=%b%b exp=00", fmt_busy, tx_req);
    end
  endtask

  task automatic test_reset_mid_conv();
    int reqs;
    tag = mk_tag("FREQ"); val = 32'd999; val_signed = 1'b0; fmt_req = 1'b1;
    step();
    fmt_req = 1'b0;
    repeat (10) step();          // n = 10: converter is mid-run
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    #1;
    checks++;
    if ({fmt_busy, fmt_done, fmt_err, tx_req} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_mid control_outputs got=%b exp=0000", {fmt_busy, fmt_done, fmt_err, tx_req});
    end
    checks++;
    if (tx_string !== '0 || tx_length !== 8'd0) begin
      failures++;
      $display("FAIL rst_mid string got=%h/%0d exp=0/0", tx_string[127:0], tx_length);
    end
    reqs = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (tx_req || fmt_done) reqs++;
    end
    checks++;
    if (reqs !== 0) begin
      failures++; $display("FAIL rst_mid abandoned_job_activity got=%0d exp=0", reqs);
    end
    run_job("after_rst", "RST", 32'd42, 1'b0, "RST=42", 0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    run_job("timeout", "FREQ", 32'd77, 1'b0, "FREQ=77", 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unsigned_bounds();
    test_signed();
    test_sparse_tag();
    test_back_pressure();
    test_reset_mid_conv();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
